// File: rtl/fir_seq_pkg.sv
// Shared constants and FSM state encoding for the time-multiplexed FIR tap sequencer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package fir_seq_pkg;

    localparam int NTAPS = 10;       // taps / delay-line depth
    localparam int XW    = 4;        // sample width
    localparam int MW    = 8;        // partial-product width from the ROM
    localparam int TW    = 4;        // tap-index width
    localparam int OW    = MW + TW;  // accumulator width, wide enough for NTAPS*(2^MW-1)

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/fir_delay_line.sv
// NTAPS-deep sample shift register with a tap-select read mux.
// Latency: shift takes effect on the next rising edge; the read mux is combinational.
// Backpressure: none; the parent only asserts shift on an accepted sample.
module fir_delay_line
    import fir_seq_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          shift,
    input  logic [XW-1:0] x_in,
    input  logic [TW-1:0] tap,
    output logic [XW-1:0] x_tap
);

    logic [XW-1:0] x [NTAPS];

    // Newest sample enters at x[0]; the oldest falls off the end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NTAPS; k++) begin
                x[k] <= '0;
            end
        end else if (shift) begin
            x[0] <= x_in;
            for (int k = 1; k < NTAPS; k++) begin
                x[k] <= x[k-1];
            end
        end
    end

    // Select x[tap]; out-of-range tap indices read as zero.
    always_comb begin
        x_tap = '0;
        for (int k = 0; k < NTAPS; k++) begin
            if (tap == TW'(k)) begin
                x_tap = x[k];
            end
        end
    end

endmodule

// File: rtl/fir_tap_sequencer.sv
// Walks the FIR taps one per cycle through a shared clocked ROM and accumulates the products.
// Latency: accept in T, ROM reads T+1..T+10, result valid from T+12; 13-cycle minimum period.
// Backpressure: in_ready low outside IDLE; result held in DONE until out_ready.
module fir_tap_sequencer
    import fir_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XW-1:0]    x_in,
    output logic             rom_en,
    output logic [TW+XW-1:0] rom_addr,
    input  logic [MW-1:0]    rom_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OW-1:0]    y_out,
    output logic             busy
);

    state_t        state;
    state_t        state_nx;
    logic [TW-1:0] tap;
    logic          rdv;
    logic [OW-1:0] acc;
    logic          in_ready_q;
    logic          accept;
    logic [XW-1:0] x_tap;

    assign accept = in_valid & in_ready_q;

    fir_delay_line u_delay_line (
        .clk   (clk),
        .rst_n (rst_n),
        .shift (accept),
        .x_in  (x_in),
        .tap   (tap),
        .x_tap (x_tap)
    );

    // Next-state logic: one pass over the taps, one drain cycle, then hold the result.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept)                  state_nx = ISSUE;
            ISSUE:   if (tap == TW'(NTAPS - 1))   state_nx = WAIT;
            WAIT:                                 state_nx = DONE;
            DONE:    if (out_ready)               state_nx = IDLE;
            default:                              state_nx = IDLE;
        endcase
    end

    // State register; in_ready is registered so it stays low while reset is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            in_ready_q <= 1'b0;
        end else begin
            state      <= state_nx;
            in_ready_q <= (state_nx == IDLE);
        end
    end

    // Tap counter: restarts on accept, advances once per issued read, wraps after the last tap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap <= '0;
        end else if (accept) begin
            tap <= '0;
        end else if (state == ISSUE) begin
            tap <= (tap == TW'(NTAPS - 1)) ? '0 : tap + 1'b1;
        end
    end

    // Read-data-valid tracks the ROM's one-cycle latency; rom_data outside it is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdv <= 1'b0;
            acc <= '0;
        end else begin
            rdv <= rom_en;
            if (accept) begin
                acc <= '0;
            end else if (rdv) begin
                acc <= acc + OW'(rom_data);
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign rom_en    = (state == ISSUE);
    assign rom_addr  = rom_en ? {tap, x_tap} : '0;
    assign out_valid = (state == DONE);
    assign y_out     = out_valid ? acc : '0;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_fir_tap_sequencer.sv
module tb_fir_tap_sequencer;
    import fir_seq_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [XW-1:0]    x_in;
    logic             rom_en;
    logic [TW+XW-1:0] rom_addr;
    logic [MW-1:0]    rom_data;
    logic             out_valid;
    logic             out_ready;
    logic [OW-1:0]    y_out;
    logic             busy;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: the samples currently in the filter, newest first.
    int mdl [NTAPS];
    bit rom_mode = 1'b0;   // 0: (tap+1)*sample, 1: constant 255
    bit garbage  = 1'b0;   // drive 0xFF on rom_data outside read-return slots

    always #5 clk = ~clk;

    fir_tap_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .rom_en    (rom_en),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y_out     (y_out),
        .busy      (busy)
    );

    // Clocked ROM model: data for an address appears the cycle after rom_en.
    always @(posedge clk) begin
        if (rom_en) begin
            if (rom_mode) rom_data <= 8'hFF;
            else          rom_data <= 8'((int'(rom_addr[7:4]) + 1) * int'(rom_addr[3:0]));
        end else begin
            rom_data <= garbage ? 8'hFF : 8'h00;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int model_y();
        int s = 0;
        for (int k = 0; k < NTAPS; k++) s += rom_mode ? 255 : (k + 1) * mdl[k];
        return s;
    endfunction

    task automatic model_push(input int v);
        for (int k = NTAPS - 1; k > 0; k--) mdl[k] = mdl[k-1];
        mdl[0] = v;
    endtask

    task automatic model_clear();
        for (int k = 0; k < NTAPS; k++) mdl[k] = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_clear();
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);
    endtask

    // One full transaction: offer xv, check every issued address, then the result.
    // hold > 0 keeps out_ready low for that many cycles in DONE with a pending sample.
    task automatic run_sample(input int xv, input int hold, output int y_seen);
        int w;
        int exp_y;
        w = 0;
        while (!in_ready && w < 40) begin
            @(negedge clk);
            w++;
        end
        check("in_ready_wait", in_ready, 1);
        in_valid  = 1'b1;
        x_in      = 4'(xv);
        out_ready = (hold == 0);
        @(posedge clk);
        model_push(xv);
        exp_y = model_y();
        @(negedge clk);
        in_valid = 1'b0;
        x_in     = 4'($urandom);
        for (int k = 0; k < NTAPS; k++) begin
            check("issue_rom_en", rom_en, 1);
            check("issue_rom_addr", rom_addr, (k << 4) | mdl[k]);
            check("issue_in_ready", in_ready, 0);
            @(negedge clk);
        end
        check("wait_rom_en", rom_en, 0);
        check("wait_out_valid", out_valid, 0);
        check("wait_busy", busy, 1);
        @(negedge clk);
        check("done_out_valid", out_valid, 1);
        check("done_y_out", y_out, exp_y);
        y_seen = int'(y_out);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            x_in     = 4'($urandom);
            @(negedge clk);
            check("hold_out_valid", out_valid, 1);
            check("hold_y_out", y_out, exp_y);
            check("hold_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_in_ready", in_ready, 1);
        check("idle_out_valid", out_valid, 0);
    endtask

    initial begin
        int y;
        bit seen_ov;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        x_in      = '0;
        out_ready = 1'b1;
        model_clear();
        #1;
        check("reset_in_ready", in_ready, 0);
        check("reset_rom_en", rom_en, 0);
        check("reset_rom_addr", rom_addr, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_y_out", y_out, 0);
        check("reset_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("release_in_ready", in_ready, 1);

        // Directed impulse-style sequence.
        run_sample(3, 0, y); check("dir_y_3", y, 3);
        run_sample(2, 0, y); check("dir_y_8", y, 8);
        run_sample(1, 0, y); check("dir_y_14", y, 14);

        // Backpressure in DONE with a pending sample that must not be taken.
        run_sample(6, 5, y);
        run_sample(4, 0, y);

        // Saturated ROM: no truncation of the 10*255 sum.
        rom_mode = 1'b1;
        for (int i = 0; i < NTAPS; i++) run_sample(15, 0, y);
        check("max_y_2550", y, 2550);
        rom_mode = 1'b0;

        // Reset in the middle of ISSUE.
        @(negedge clk);
        check("abort_in_ready", in_ready, 1);
        in_valid = 1'b1;
        x_in     = 4'd9;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        model_clear();
        #1;
        check("abort_in_ready_rst", in_ready, 0);
        check("abort_rom_en", rom_en, 0);
        check("abort_rom_addr", rom_addr, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_y_out", y_out, 0);
        check("abort_busy", busy, 0);
        @(negedge clk);
        rst_n   = 1'b1;
        seen_ov = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            seen_ov |= out_valid;
        end
        check("abort_no_out_valid", seen_ov, 0);
        run_sample(5, 0, y); check("abort_y_5", y, 5);

        // Garbage on rom_data outside read slots must not change results.
        do_reset();
        garbage = 1'b1;
        run_sample(3, 0, y); check("garb_y_3", y, 3);
        run_sample(2, 0, y); check("garb_y_8", y, 8);
        run_sample(1, 0, y); check("garb_y_14", y, 14);

        // Randomised traffic against the model.
        for (int i = 0; i < 40; i++) begin
            garbage = 1'($urandom);
            run_sample(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), y);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
